fall_alarm_ctrl: RTL and testbench
==================================

FALL_ALARM_CTRL -- requirements
Module: fall_alarm_ctrl

Interface
REQ-001 Parameter CONFIRM_CYC, default 250_000_000, clk cycles fall must persist before alarm (5 s at 50 MHz).
REQ-002 Parameter COOLDOWN_CYC, default 3_000_000_000, clk cycles after an alarm during which new falls are ignored (60 s); counter width 32 bits.
REQ-003 Parameter DB_CYC, default 1_000_000, clk cycles of stable key level required by debounce (20 ms).
REQ-004 Parameter SMS_PULSE_CYC, default 50_000, cycles sms_en stays high per alarm (1 ms).
REQ-005 clk  input  1  system clock, 50 MHz domain; the only clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fall_flag  input  1  fall level from the GY25 stage (led_GY25[0]); asynchronous to clk.
REQ-008 cancel_key  input  1  raw user button, active-low, asynchronous, bouncing.
REQ-009 sms_en  output  1  SMS send enable to the GSM/GPS SMS stage, high for SMS_PULSE_CYC cycles per alarm.
REQ-010 vibrate  output  1  vibration motor drive.
REQ-011 state  output  2  current state: 00 IDLE, 01 CONFIRM, 10 ALERT, 11 COOLDOWN.
REQ-012 alarm_cnt  output  8  number of alarms issued since reset, saturating.

Function
REQ-013 fall_flag and cancel_key shall each pass through a 2-flop synchronizer before any use.
REQ-014 Debounced key level shall change only after DB_CYC consecutive identical synchronized samples; cancel pulse = one cycle on debounced 1->0 transition.
REQ-015 IDLE: fall_s high -> CONFIRM, timer cleared; latency fall_flag rise to state=01 is 3 cycles.
REQ-016 CONFIRM: timer increments each cycle; cancel pulse -> IDLE; fall_s low -> IDLE; timer == CONFIRM_CYC-1 -> ALERT.
REQ-017 CONFIRM same-cycle conflicts: cancel beats timeout; fall_s low beats timeout.
REQ-018 ALERT: sms_en high exactly SMS_PULSE_CYC cycles starting the first ALERT cycle, then -> COOLDOWN; cancel and fall_s ignored.
REQ-019 On ALERT entry alarm_cnt increments by 1, saturating at 255 (no wrap).
REQ-020 COOLDOWN: timer counts COOLDOWN_CYC cycles then -> IDLE; fall_s and cancel ignored; if fall_s still high at exit, IDLE re-enters CONFIRM next cycle.
REQ-021 vibrate high in CONFIRM and ALERT, low in IDLE and COOLDOWN; registered, tracks state with no added cycle.
REQ-022 sms_en shall never be high outside ALERT; at most one sms_en pulse per ALERT visit.
REQ-023 One shared timer serves CONFIRM, ALERT pulse, COOLDOWN; cleared on every state change.

Reset
REQ-024 While rst is high at a clk edge: state IDLE, sms_en 0, vibrate 0, alarm_cnt 0, timer 0, synchronizers 0 for fall, 1 for key, debounced key 1.
REQ-025 rst asserted mid-CONFIRM/ALERT/COOLDOWN shall abort immediately; sms_en drops on the reset edge; no pulse resumes after release.

Structure
REQ-026 Shared package holds state encoding constants and default cycle counts (CONFIRM, COOLDOWN, DB, SMS_PULSE at 50 MHz).
REQ-027 Key synchronizer+debounce+falling-edge pulse shall be one sub-module, key_debounce, parameterized by DB_CYC.
REQ-028 FSM, timer, counter in fall_alarm_ctrl; no other sub-modules.

Verification (bench params CONFIRM_CYC=100, COOLDOWN_CYC=200, DB_CYC=4, SMS_PULSE_CYC=8)
REQ-029 fall_flag high held -> state=01 3 cycles later, vibrate=1; 100 cycles later state=10, sms_en high exactly 8 cycles, alarm_cnt=1, then state=11 for 200 cycles, then 00.
REQ-030 fall_flag high 50 cycles then low -> returns to IDLE, sms_en never asserted, alarm_cnt=0.
REQ-031 fall held, key pressed (low 10 cycles, with 2-cycle bounces first) during CONFIRM -> IDLE within debounce+3 cycles, no sms_en; a 3-cycle glitch alone causes no cancel.
REQ-032 Cancel pulse arriving on the timeout cycle -> IDLE, no ALERT; key press during ALERT -> sms_en still 8 cycles.
REQ-033 fall held continuously through 300 alarms -> alarm_cnt saturates at 255; fall re-pulsed during COOLDOWN ignored.
REQ-034 rst high for 1 cycle at sms_en cycle 3 -> all outputs zero next edge, state=00, alarm_cnt=0.

Source files
------------

// File: rtl/fall_alarm_ctrl_pkg.sv
// Shared definitions for the fall alarm controller: state encoding,
// default cycle counts at 50 MHz and the saturating alarm counter helper.
package fall_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CONFIRM  = 2'b01,
    ST_ALERT    = 2'b10,
    ST_COOLDOWN = 2'b11
  } state_t;

  // 5 s of persistent fall before the alarm fires
  localparam int          CONFIRM_CYC_DEF   = 250_000_000;
  // 60 s hold-off after an alarm; exceeds int range, so kept as 32-bit unsigned
  localparam logic [31:0] COOLDOWN_CYC_DEF  = 32'd3_000_000_000;
  // 20 ms of stable key level
  localparam int          DB_CYC_DEF        = 1_000_000;
  // 1 ms SMS enable pulse
  localparam int          SMS_PULSE_CYC_DEF = 50_000;

  localparam logic [7:0]  ALARM_CNT_MAX     = 8'd255;

  // Alarm counter sticks at its maximum instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ALARM_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fall_alarm_ctrl_if.sv
// Signal bundle between the fall alarm controller and its surroundings:
// fall level and cancel key in, SMS enable, motor and status out.
interface fall_alarm_ctrl_if;
  import fall_alarm_ctrl_pkg::*;

  logic       fall_flag;
  logic       cancel_key;
  logic       sms_en;
  logic       vibrate;
  state_t     state;
  logic [7:0] alarm_cnt;

  // Surrounding system: drives sensor and key, observes alarm outputs
  modport master (
    output fall_flag, cancel_key,
    input  sms_en, vibrate, state, alarm_cnt
  );

  // Controller side
  modport slave (
    input  fall_flag, cancel_key,
    output sms_en, vibrate, state, alarm_cnt
  );

endinterface

// File: rtl/fall_alarm_ctrl_key_debounce.sv
// Cancel button conditioning: 2-flop synchronizer, counter debounce and a
// one-cycle pulse when the debounced (active-low) level falls.
module key_debounce
  import fall_alarm_ctrl_pkg::*;
#(
  parameter int DB_CYC = DB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic cancel
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic          key_m;
  logic          key_s;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize the raw key; idle level of the button is high
  always_ff @(posedge clk) begin
    if (rst) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

  // Accept a new level only after DB_CYC consecutive differing samples;
  // any sample matching the current level restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 1'b1;
      cnt    <= '0;
      cancel <= 1'b0;
    end else begin
      cancel <= 1'b0;
      if (key_s == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level  <= key_s;
        cnt    <= '0;
        // only the 1->0 (press) transition produces a cancel
        cancel <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fall_alarm_ctrl.sv
// Fall alarm controller: a sustained fall level is confirmed for
// CONFIRM_CYC cycles (user can cancel), then an SMS pulse is issued and the
// controller holds off new falls for COOLDOWN_CYC cycles.
module fall_alarm_ctrl
  import fall_alarm_ctrl_pkg::*;
#(
  parameter int          CONFIRM_CYC   = CONFIRM_CYC_DEF,
  parameter logic [31:0] COOLDOWN_CYC  = COOLDOWN_CYC_DEF,
  parameter int          DB_CYC        = DB_CYC_DEF,
  parameter int          SMS_PULSE_CYC = SMS_PULSE_CYC_DEF
) (
  input logic               clk,
  input logic               rst,
  fall_alarm_ctrl_if.slave  bus
);

  // Terminal timer values: each timed state lasts exactly N cycles
  localparam logic [31:0] CONFIRM_LAST  = 32'(CONFIRM_CYC - 1);
  localparam logic [31:0] COOLDOWN_LAST = COOLDOWN_CYC - 32'd1;
  localparam logic [31:0] SMS_LAST      = 32'(SMS_PULSE_CYC - 1);

  logic        fall_m;
  logic        fall_s;
  logic        cancel;
  state_t      st;
  logic [31:0] timer;
  logic        sms_q;
  logic        vib_q;
  logic [7:0]  cnt_q;

  // Fall level comes from another clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_m <= 1'b0;
      fall_s <= 1'b0;
    end else begin
      fall_m <= bus.fall_flag;
      fall_s <= fall_m;
    end
  end

  key_debounce #(.DB_CYC(DB_CYC)) u_key (
    .clk    (clk),
    .rst    (rst),
    .key    (bus.cancel_key),
    .cancel (cancel)
  );

  // Alarm sequencer; one shared timer restarts on every state change and
  // outputs are registered alongside the state so they never lag it
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_IDLE;
      timer <= '0;
      sms_q <= 1'b0;
      vib_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          timer <= '0;
          if (fall_s) begin
            st    <= ST_CONFIRM;
            vib_q <= 1'b1;
          end
        end
        ST_CONFIRM: begin
          // cancel and a dropped fall both take priority over the timeout
          if (cancel || !fall_s) begin
            st    <= ST_IDLE;
            timer <= '0;
            vib_q <= 1'b0;
          end else if (timer == CONFIRM_LAST) begin
            st    <= ST_ALERT;
            timer <= '0;
            sms_q <= 1'b1;
            cnt_q <= sat_inc(cnt_q);
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_ALERT: begin
          // sms_en spans the whole ALERT visit, so it is exactly one pulse
          if (timer == SMS_LAST) begin
            st    <= ST_COOLDOWN;
            timer <= '0;
            sms_q <= 1'b0;
            vib_q <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_COOLDOWN: begin
          if (timer == COOLDOWN_LAST) begin
            st    <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          st    <= ST_IDLE;
          timer <= '0;
          sms_q <= 1'b0;
          vib_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.sms_en    = sms_q;
  assign bus.vibrate   = vib_q;
  assign bus.alarm_cnt = cnt_q;

endmodule

// File: tb/tb_fall_alarm_ctrl.sv
// Directed bench for fall_alarm_ctrl with short timing parameters.
module tb_fall_alarm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fall_alarm_ctrl_if bus();

  fall_alarm_ctrl #(
    .CONFIRM_CYC   (100),
    .COOLDOWN_CYC  (32'd200),
    .DB_CYC        (4),
    .SMS_PULSE_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    r;
    bit    fall;
    bit    key;
    int    adv;
    int    st;
    int    vib;
    int    sms;
    int    cnt;
  } vec_t;

  vec_t tbl[$];

  int pass_cnt = 0;
  int total    = 0;
  int sms_cyc  = 0;
  int sms_bad  = 0;
  int vib_bad  = 0;

  // Continuous observers: sms only in ALERT, vibrate only in CONFIRM/ALERT
  always @(negedge clk) begin
    if (bus.sms_en) sms_cyc = sms_cyc + 1;
    if (bus.sms_en && bus.state != 2'b10) sms_bad = sms_bad + 1;
    if (bus.vibrate != (bus.state == 2'b01 || bus.state == 2'b10)) vib_bad = vib_bad + 1;
  end

  function automatic vec_t mk(string nm, bit r, bit f, bit k, int adv,
                              int st, int v, int s, int c);
    vec_t x;
    x.name = nm; x.r = r; x.fall = f; x.key = k; x.adv = adv;
    x.st = st; x.vib = v; x.sms = s; x.cnt = c;
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    total = total + 1;
    if (got === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_out(input string name, input int st, input int vib,
                           input int sms, input int cnt);
    check({name, "_state"}, int'(bus.state), st);
    check({name, "_vib"},   int'(bus.vibrate), vib);
    check({name, "_sms"},   int'(bus.sms_en), sms);
    check({name, "_cnt"},   int'(bus.alarm_cnt), cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fall_flag  = 1'b0;
    bus.cancel_key = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.fall_flag  = 1'b0;
    bus.cancel_key = 1'b1;
    @(negedge clk);

    // Vector table: inputs held for adv cycles, then outputs checked
    tbl.push_back(mk("reset",        1, 0, 1,   2, 0, 0, 0, 0));
    tbl.push_back(mk("idle_c2",      0, 1, 1,   2, 0, 0, 0, 0));
    tbl.push_back(mk("confirm_c3",   0, 1, 1,   1, 1, 1, 0, 0));
    tbl.push_back(mk("confirm_c102", 0, 1, 1,  99, 1, 1, 0, 0));
    tbl.push_back(mk("alert_c103",   0, 1, 1,   1, 2, 1, 1, 1));
    tbl.push_back(mk("alert_c110",   0, 1, 1,   7, 2, 1, 1, 1));
    tbl.push_back(mk("cool_c111",    0, 1, 1,   1, 3, 0, 0, 1));
    tbl.push_back(mk("cool_c310",    0, 1, 1, 199, 3, 0, 0, 1));
    tbl.push_back(mk("idle_c311",    0, 1, 1,   1, 0, 0, 0, 1));
    tbl.push_back(mk("reconfirm",    0, 1, 1,   1, 1, 1, 0, 1));
    tbl.push_back(mk("drop_sync",    0, 0, 1,   2, 1, 1, 0, 1));
    tbl.push_back(mk("drop_idle",    0, 0, 1,   1, 0, 0, 0, 1));
    tbl.push_back(mk("reset2",       1, 0, 1,   1, 0, 0, 0, 0));
    tbl.push_back(mk("short_c3",     0, 1, 1,   3, 1, 1, 0, 0));
    tbl.push_back(mk("short_c50",    0, 1, 1,  47, 1, 1, 0, 0));
    tbl.push_back(mk("short_drop",   0, 0, 1,   2, 1, 1, 0, 0));
    tbl.push_back(mk("short_idle",   0, 0, 1,   1, 0, 0, 0, 0));
    tbl.push_back(mk("short_settle", 0, 0, 1,  10, 0, 0, 0, 0));

    sms_cyc = 0;
    foreach (tbl[i]) begin
      rst            = tbl[i].r;
      bus.fall_flag  = tbl[i].fall;
      bus.cancel_key = tbl[i].key;
      tick(tbl[i].adv);
      check_out(tbl[i].name, tbl[i].st, tbl[i].vib, tbl[i].sms, tbl[i].cnt);
    end
    check("main_sms_len", sms_cyc, 8);

    // Bouncy press during CONFIRM cancels exactly DB_CYC+3 cycles after
    // the key settles low
    do_reset();
    sms_cyc = 0;
    bus.fall_flag = 1'b1;
    tick(3);
    check("cancel_in_confirm", int'(bus.state), 1);
    repeat (2) begin
      bus.cancel_key = 1'b0; tick(2);
      bus.cancel_key = 1'b1; tick(2);
    end
    bus.cancel_key = 1'b0;
    tick(6);
    check("cancel_not_yet", int'(bus.state), 1);
    tick(1);
    check("cancel_idle", int'(bus.state), 0);
    check("cancel_vib", int'(bus.vibrate), 0);
    bus.fall_flag = 1'b0;
    tick(3);
    bus.cancel_key = 1'b1;
    tick(20);
    check("cancel_settle", int'(bus.state), 0);
    check("cancel_cnt", int'(bus.alarm_cnt), 0);
    check("cancel_no_sms", sms_cyc, 0);

    // A 3-cycle glitch is shorter than the debounce window
    do_reset();
    bus.fall_flag = 1'b1;
    tick(3);
    bus.cancel_key = 1'b0;
    tick(3);
    bus.cancel_key = 1'b1;
    tick(12);
    check("glitch_no_cancel", int'(bus.state), 1);
    bus.fall_flag = 1'b0;
    tick(4);
    check("glitch_drop_idle", int'(bus.state), 0);

    // Cancel pulse lands on the timeout cycle
    do_reset();
    sms_cyc = 0;
    bus.fall_flag = 1'b1;
    tick(96);
    bus.cancel_key = 1'b0;
    tick(6);
    check("tmo_cancel_pre", int'(bus.state), 1);
    tick(1);
    check("tmo_cancel_idle", int'(bus.state), 0);
    check("tmo_cancel_cnt", int'(bus.alarm_cnt), 0);
    bus.fall_flag = 1'b0;
    tick(3);
    bus.cancel_key = 1'b1;
    tick(20);
    check("tmo_cancel_sms", sms_cyc, 0);

    // Fall drop seen on the timeout cycle
    do_reset();
    bus.fall_flag = 1'b1;
    tick(100);
    bus.fall_flag = 1'b0;
    tick(2);
    check("tmo_drop_pre", int'(bus.state), 1);
    tick(1);
    check("tmo_drop_idle", int'(bus.state), 0);
    check("tmo_drop_cnt", int'(bus.alarm_cnt), 0);

    // Key press in ALERT is ignored; fall re-pulse in COOLDOWN ignored
    do_reset();
    sms_cyc = 0;
    bus.fall_flag = 1'b1;
    tick(103);
    check("alert_key_state", int'(bus.state), 2);
    bus.cancel_key = 1'b0;
    tick(8);
    bus.cancel_key = 1'b1;
    check("alert_key_cool", int'(bus.state), 3);
    check("alert_key_sms_len", sms_cyc, 8);
    bus.fall_flag = 1'b0; tick(5);
    bus.fall_flag = 1'b1; tick(5);
    bus.fall_flag = 1'b0; tick(29);
    check_out("refall_c150", 3, 0, 0, 1);
    tick(160);
    check("refall_c310", int'(bus.state), 3);
    tick(1);
    check("refall_exit", int'(bus.state), 0);
    tick(10);
    check_out("refall_idle", 0, 0, 0, 1);
    check("refall_sms_len", sms_cyc, 8);

    // Continuous fall: 256 alarms, counter must stop at 255
    do_reset();
    bus.fall_flag = 1'b1;
    tick(103);
    for (int k = 0; k < 256; k++) begin
      check("sat_state", int'(bus.state), 2);
      check("sat_cnt", int'(bus.alarm_cnt), (k + 1 > 255) ? 255 : k + 1);
      if (k < 255) tick(309);
    end

    // Reset during the third sms_en cycle
    tick(2);
    check("rst_mid_sms", int'(bus.sms_en), 1);
    rst = 1'b1;
    bus.fall_flag = 1'b0;
    tick(1);
    rst = 1'b0;
    check_out("rst_mid_alert", 0, 0, 0, 0);
    sms_cyc = 0;
    tick(20);
    check("rst_no_resume", sms_cyc, 0);
    check("rst_idle", int'(bus.state), 0);

    check("sms_outside_alert", sms_bad, 0);
    check("vib_tracks_state", vib_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
